dti_iniu_pr: RTL and testbench

Parametrised DTI initiator NIU with per-TBU partial reset, sitting between the DTI-TBU AXI-Stream ports and the custom NoC request/response channels. Tracks a connection FSM per TBU. On a per-TBU partial-reset request it terminates that TBU's open transaction and injects a DTI disconnect. It then waits for the disconnect ACK while all other TBUs keep full bandwidth. Adds round-robin reset servicing, ACK timeout and per-TBU status.

---
 rtl/dti_iniu_pr.sv | 155 +++++++++++++++
 tb/tb_dti_iniu_pr.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dti_iniu_pr.sv
// dti_iniu_pr: DTI initiator NIU with per-TBU partial reset between DTI-TBU AXI-Stream and NoC channels
// Ports: clk/rst_n (sync, active-low); pr_req/pr_done/timeout_err/tbu_idle/idle reset control and status;
//        req_t*/rsp_t* upstream DTI streams; req_*/rsp_* NoC request/response channels.
module dti_iniu_pr #(
  parameter int TBU_NUM = 8,
  parameter int TID_W   = 6,
  parameter int DATA_W  = 80,
  parameter int KEEP_W  = DATA_W / 8,
  parameter int TO_W    = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [TBU_NUM-1:0]       pr_req,
  output logic [TBU_NUM-1:0]       pr_done,
  output logic                     timeout_err,
  output logic [TBU_NUM-1:0]       tbu_idle,
  output logic                     idle,
  input  logic                     req_tvalid,
  output logic                     req_tready,
  input  logic [DATA_W-1:0]        req_tdata,
  input  logic [KEEP_W-1:0]        req_tkeep,
  input  logic                     req_tlast,
  input  logic [TID_W-1:0]         req_tid,
  output logic                     rsp_tvalid,
  input  logic                     rsp_tready,
  output logic [DATA_W-1:0]        rsp_tdata,
  output logic [KEEP_W-1:0]        rsp_tkeep,
  output logic                     rsp_tlast,
  output logic [TID_W-1:0]         rsp_tid,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [DATA_W+KEEP_W-1:0] req_payload,
  output logic [TID_W-1:0]         req_srcid,
  output logic [TID_W-1:0]         req_tgtid,
  output logic                     req_qos,
  output logic                     req_last,
  input  logic                     req_threshold,
  input  logic                     rsp_valid,
  output logic                     rsp_ready,
  input  logic [DATA_W+KEEP_W-1:0] rsp_payload,
  input  logic [TID_W-1:0]         rsp_srcid,
  input  logic [TID_W-1:0]         rsp_tgtid,
  input  logic                     rsp_qos,
  input  logic                     rsp_last,
  output logic                     rsp_threshold
);
  localparam int IW = $clog2(TBU_NUM);
  typedef enum logic [2:0] {S_IDLE, S_CONN, S_TRANS, S_TERM, S_DISC, S_WAIT} st_t;
  st_t              r_st [TBU_NUM];
  st_t              w_nxt [TBU_NUM];
  logic [TBU_NUM-1:0] r_pend, r_done;
  logic             r_to, r_act;
  logic [IW-1:0]    r_tgt, w_sel, w_j;
  logic [TO_W-1:0]  r_cnt;
  logic [TBU_NUM-1:0] w_req_hit, w_rsp_hit, w_busy, w_cand, w_done, w_idle_req;
  logic             w_inj, w_inj_acc, w_req_blk, w_rsp_blk, w_up_hs, w_ack, w_ack_st;
  logic             w_tgt_wait, w_tgt_ack, w_to, w_sel_ok, w_sel_go, w_unused;
  assign w_unused = ^{req_threshold, rsp_qos};
  always_comb begin
    for (int i = 0; i < TBU_NUM; i++) begin
      w_req_hit[i]  = req_tid == TID_W'(i);
      w_rsp_hit[i]  = rsp_srcid == TID_W'(i);
      w_busy[i]     = r_st[i] inside {S_TERM, S_DISC, S_WAIT};
      tbu_idle[i]   = r_st[i] == S_IDLE;
    end
  end
  assign idle       = &tbu_idle;
  assign w_cand     = r_pend & ~tbu_idle;
  assign w_tgt_wait = r_act && r_st[r_tgt] == S_WAIT;
  assign w_inj      = r_act && (r_st[r_tgt] == S_TERM || r_st[r_tgt] == S_DISC);
  assign w_inj_acc  = w_inj && req_ready;
  // Beats for a TBU being reset (or queued for reset) are swallowed so they never reach the NoC.
  assign w_req_blk  = |(w_req_hit & (w_busy | r_pend));
  assign w_rsp_blk  = |(w_rsp_hit & w_busy);
  assign req_tready = !w_inj && (w_req_blk || req_ready);
  assign req_valid  = w_inj || (req_tvalid && !w_req_blk);
  assign req_payload = w_inj ? {{DATA_W{1'b0}}, (r_st[r_tgt] == S_TERM ? {KEEP_W{1'b1}} : KEEP_W'(4'hf))}
                             : {req_tdata, req_tkeep};
  assign req_srcid  = w_inj ? TID_W'(r_tgt) : req_tid;
  assign req_last   = w_inj || req_tlast;
  assign req_tgtid  = '0;
  assign req_qos    = 1'b1;
  assign w_up_hs    = req_tvalid && !w_inj && !w_req_blk && req_ready;
  assign rsp_ready  = w_rsp_blk || rsp_tready;
  assign rsp_tvalid = rsp_valid && !w_rsp_blk;
  assign rsp_tdata  = rsp_payload[DATA_W+KEEP_W-1:KEEP_W];
  assign rsp_tkeep  = rsp_payload[KEEP_W-1:0];
  assign rsp_tid    = rsp_tgtid;
  assign rsp_tlast  = rsp_last;
  assign rsp_threshold = 1'b1;
  assign w_ack      = rsp_valid && rsp_ready && rsp_payload[KEEP_W+3:KEEP_W] == 4'h0;
  assign w_ack_st   = rsp_payload[KEEP_W+4];
  assign w_tgt_ack  = w_tgt_wait && w_ack && !w_ack_st && w_rsp_hit[r_tgt];
  // An ACK arriving on the expiry cycle wins over the timeout.
  assign w_to       = w_tgt_wait && (&r_cnt) && !w_tgt_ack;
  assign w_sel_go   = !r_act && w_sel_ok;
  // Scan downwards so the nearest candidate after the last target is the one left standing.
  always_comb begin
    w_sel_ok = 1'b0;
    w_sel    = '0;
    w_j      = '0;
    for (int k = TBU_NUM; k >= 1; k--) begin
      w_j = IW'((int'(r_tgt) + k) % TBU_NUM);
      if (w_cand[w_j]) begin
        w_sel_ok = 1'b1;
        w_sel    = w_j;
      end
    end
  end
  // Traffic-driven update first, reset selection applied on top of its result.
  always_comb begin
    for (int i = 0; i < TBU_NUM; i++) begin
      w_nxt[i]      = r_st[i];
      w_done[i]     = r_pend[i] && (tbu_idle[i] || (r_tgt == IW'(i) && (w_tgt_ack || w_to)));
      w_idle_req[i] = pr_req[i] && !r_pend[i] && tbu_idle[i];
      if (w_up_hs && w_req_hit[i])
        w_nxt[i] = (r_st[i] == S_CONN && !req_tlast) ? S_TRANS :
                   (r_st[i] == S_TRANS && req_tlast) ? S_CONN : r_st[i];
      if (w_ack && w_rsp_hit[i])
        w_nxt[i] = (r_st[i] == S_IDLE && w_ack_st) ? S_CONN :
                   ((r_st[i] == S_CONN || r_st[i] == S_WAIT) && !w_ack_st) ? S_IDLE : w_nxt[i];
      if (r_tgt == IW'(i) && w_inj_acc)
        w_nxt[i] = r_st[i] == S_TERM ? S_DISC : S_WAIT;
      if (r_tgt == IW'(i) && w_to)
        w_nxt[i] = S_IDLE;
      if (w_sel_go && w_sel == IW'(i))
        w_nxt[i] = w_nxt[i] == S_TRANS ? S_TERM : w_nxt[i] == S_CONN ? S_DISC : w_nxt[i];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TBU_NUM; i++) r_st[i] <= S_IDLE;
      r_pend <= '0;
      r_done <= '0;
      r_to   <= 1'b0;
      r_act  <= 1'b0;
      r_tgt  <= IW'(TBU_NUM - 1);
      r_cnt  <= '0;
    end else begin
      for (int i = 0; i < TBU_NUM; i++) r_st[i] <= w_nxt[i];
      r_pend <= (r_pend | (pr_req & ~tbu_idle)) & ~w_done;
      r_done <= w_done | w_idle_req;
      r_to   <= w_to;
      if (w_sel_go) begin
        r_act <= 1'b1;
        r_tgt <= w_sel;
      end else if (r_act && w_done[r_tgt]) begin
        r_act <= 1'b0;
      end
      r_cnt <= (w_inj_acc && r_st[r_tgt] == S_DISC) ? '0 : w_tgt_wait ? r_cnt + 1'b1 : r_cnt;
    end
  end
  assign pr_done     = r_done;
  assign timeout_err = r_to;
endmodule

// File: tb/tb_dti_iniu_pr.sv
// tb_dti_iniu_pr: scoreboard bench for the DTI initiator NIU partial-reset flow
module tb_dti_iniu_pr;
  localparam int N = 8, TW = 6, DW = 80, KW = 10, PW = 90;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] pr_req = '0, pr_done, tbu_idle;
  logic timeout_err, idle;
  logic req_tvalid = 1'b0, req_tready, req_tlast = 1'b0;
  logic [DW-1:0] req_tdata = '0;
  logic [KW-1:0] req_tkeep = '0;
  logic [TW-1:0] req_tid = '0;
  logic rsp_tvalid, rsp_tready = 1'b1, rsp_tlast;
  logic [DW-1:0] rsp_tdata;
  logic [KW-1:0] rsp_tkeep;
  logic [TW-1:0] rsp_tid;
  logic req_valid, req_ready = 1'b1, req_qos, req_last, req_threshold = 1'b0;
  logic [PW-1:0] req_payload, rsp_payload = '0;
  logic [TW-1:0] req_srcid, req_tgtid, rsp_srcid = '0, rsp_tgtid = '0;
  logic rsp_valid = 1'b0, rsp_ready, rsp_qos = 1'b0, rsp_last = 1'b0, rsp_threshold;
  logic [PW+TW:0]      req_q[$];
  logic [DW+KW+TW:0]   rsp_q[$];
  logic [N:0]          done_q[$];
  logic [PW+TW:0]      m_req;
  logic [DW+KW+TW:0]   m_rsp;
  logic [N:0]          m_done;
  int total = 0, bad = 0;

  dti_iniu_pr #(.TBU_NUM(N), .TID_W(TW), .DATA_W(DW), .KEEP_W(KW), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .pr_req(pr_req), .pr_done(pr_done), .timeout_err(timeout_err),
    .tbu_idle(tbu_idle), .idle(idle),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata), .req_tkeep(req_tkeep),
    .req_tlast(req_tlast), .req_tid(req_tid),
    .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tdata(rsp_tdata), .rsp_tkeep(rsp_tkeep),
    .rsp_tlast(rsp_tlast), .rsp_tid(rsp_tid),
    .req_valid(req_valid), .req_ready(req_ready), .req_payload(req_payload), .req_srcid(req_srcid),
    .req_tgtid(req_tgtid), .req_qos(req_qos), .req_last(req_last), .req_threshold(req_threshold),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload(rsp_payload), .rsp_srcid(rsp_srcid),
    .rsp_tgtid(rsp_tgtid), .rsp_qos(rsp_qos), .rsp_last(rsp_last), .rsp_threshold(rsp_threshold)
  );

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (req_valid && req_ready) begin
      if (req_q.size() == 0) begin
        total++; bad++;
        $display("FAIL req_unexpected src=%0h payload=%0h", req_srcid, req_payload);
      end else begin
        m_req = req_q.pop_front();
        chk("req_beat", {req_payload, req_srcid, req_last}, m_req);
        chk("req_tgt_qos", {req_tgtid, req_qos}, {6'd0, 1'b1});
      end
    end
    if (rsp_tvalid && rsp_tready) begin
      if (rsp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_unexpected tid=%0h data=%0h", rsp_tid, rsp_tdata);
      end else begin
        m_rsp = rsp_q.pop_front();
        chk("rsp_beat", {rsp_tdata, rsp_tkeep, rsp_tid, rsp_tlast}, m_rsp);
      end
    end
    if (pr_done !== '0 || timeout_err !== 1'b0) begin
      if (done_q.size() == 0) begin
        total++; bad++;
        $display("FAIL done_unexpected pr_done=%0h to=%0b", pr_done, timeout_err);
      end else begin
        m_done = done_q.pop_front();
        chk("done_event", {pr_done, timeout_err}, m_done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack(input int s, input logic st, input logic pass);
    rsp_valid = 1'b1;
    rsp_srcid = TW'(s);
    rsp_tgtid = TW'(s + 16);
    rsp_payload = '0;
    rsp_payload[KW+4] = st;
    rsp_last = 1'b1;
    if (pass) rsp_q.push_back({(st ? 80'h10 : 80'h0), 10'h0, TW'(s + 16), 1'b1});
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic beat(input int t, input logic [DW-1:0] d, input logic l, input logic pass);
    req_tvalid = 1'b1;
    req_tid = TW'(t);
    req_tdata = d;
    req_tkeep = 10'h155;
    req_tlast = l;
    if (pass) req_q.push_back({d, 10'h155, TW'(t), l});
    #1;
    if (!pass) begin
      chk("sink_tready", req_tready, 1);
      chk("sink_valid", req_valid, 0);
    end
    tick();
    req_tvalid = 1'b0;
  endtask

  task automatic pr(input logic [N-1:0] v);
    pr_req = v;
    tick();
    pr_req = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_idle", idle, 1);
    chk("rst_tbu_idle", tbu_idle, 8'hff);
    chk("rst_done", {pr_done, timeout_err}, 0);
    chk("rst_req_valid", req_valid, 0);
    rst_n = 1'b1;
    tick();
    // TBU 3: connect, then partial reset from CONNECTED
    ack(3, 1'b1, 1'b1);
    chk("a_conn", tbu_idle[3], 0);
    req_q.push_back({80'h0, 10'h00f, 6'd3, 1'b1});
    pr(8'h08);
    chk("a_n1_novalid", req_valid, 0);
    tick();
    chk("a_n2_valid", req_valid, 1);
    chk("a_n2_src", req_srcid, 3);
    chk("a_n2_pl", req_payload, 90'hf);
    chk("a_n2_last", req_last, 1);
    tick();
    chk("a_wait_novalid", req_valid, 0);
    done_q.push_back({8'h08, 1'b0});
    ack(3, 1'b0, 1'b0);
    chk("a_done", pr_done, 8'h08);
    chk("a_idle3", tbu_idle[3], 1);
    // TBU 2 mid-packet, TBU 5 keeps flowing
    ack(2, 1'b1, 1'b1);
    ack(5, 1'b1, 1'b1);
    beat(2, 80'h1234, 1'b0, 1'b1);
    req_q.push_back({80'h0, 10'h3ff, 6'd2, 1'b1});
    req_q.push_back({80'h0, 10'h00f, 6'd2, 1'b1});
    pr(8'h04);
    req_tvalid = 1'b1; req_tid = 6'd2; req_tlast = 1'b0;
    #1;
    chk("b_pend_sink_tready", req_tready, 1);
    chk("b_pend_sink_valid", req_valid, 0);
    tick();
    req_tid = 6'd5;
    #1;
    chk("b_term_valid", req_valid, 1);
    chk("b_term_pl", req_payload, {80'h0, 10'h3ff});
    chk("b_block_up", req_tready, 0);
    tick();
    req_tvalid = 1'b0;
    #1;
    chk("b_condis_pl", req_payload, 90'hf);
    tick();
    beat(2, 80'h99, 1'b1, 1'b0);
    beat(5, 80'hab, 1'b0, 1'b1);
    beat(5, 80'hcd, 1'b1, 1'b1);
    done_q.push_back({8'h04, 1'b0});
    ack(2, 1'b0, 1'b0);
    chk("b_idle2", tbu_idle[2], 1);
    // TBU 7 ACK timeout with TO_W=4
    ack(7, 1'b1, 1'b1);
    req_q.push_back({80'h0, 10'h00f, 6'd7, 1'b1});
    pr(8'h80);
    tick();
    chk("d_inj_src", req_srcid, 7);
    tick();
    repeat (15) tick();
    chk("d_not_yet", pr_done, 0);
    done_q.push_back({8'h80, 1'b1});
    tick();
    chk("d_done", pr_done, 8'h80);
    chk("d_to", timeout_err, 1);
    chk("d_idle7", tbu_idle[7], 1);
    // Round robin: 1,4,6 together, then 1 again while 4 waits
    ack(1, 1'b1, 1'b1);
    ack(4, 1'b1, 1'b1);
    ack(6, 1'b1, 1'b1);
    req_q.push_back({80'h0, 10'h00f, 6'd1, 1'b1});
    req_q.push_back({80'h0, 10'h00f, 6'd4, 1'b1});
    req_q.push_back({80'h0, 10'h00f, 6'd6, 1'b1});
    req_q.push_back({80'h0, 10'h00f, 6'd1, 1'b1});
    pr(8'b0101_0010);
    tick();
    chk("c_first", {req_valid, req_srcid}, {1'b1, 6'd1});
    tick();
    done_q.push_back({8'h02, 1'b0});
    ack(1, 1'b0, 1'b0);
    chk("c_gap1", req_valid, 0);
    tick();
    chk("c_second", {req_valid, req_srcid}, {1'b1, 6'd4});
    tick();
    ack(1, 1'b1, 1'b1);
    pr(8'h02);
    done_q.push_back({8'h10, 1'b0});
    ack(4, 1'b0, 1'b0);
    chk("c_gap2", req_valid, 0);
    tick();
    chk("c_third", {req_valid, req_srcid}, {1'b1, 6'd6});
    tick();
    done_q.push_back({8'h40, 1'b0});
    ack(6, 1'b0, 1'b0);
    tick();
    chk("c_fourth", {req_valid, req_srcid}, {1'b1, 6'd1});
    tick();
    done_q.push_back({8'h02, 1'b0});
    ack(1, 1'b0, 1'b0);
    chk("c_tbu_idle", tbu_idle, 8'hdf);
    // pr_req on an IDLE TBU, then reset during a held injection
    done_q.push_back({8'h01, 1'b0});
    pr(8'h01);
    chk("e_done0", pr_done, 8'h01);
    chk("e_novalid", req_valid, 0);
    tick();
    chk("e_done_once", pr_done, 0);
    ack(3, 1'b1, 1'b1);
    req_ready = 1'b0;
    pr(8'h08);
    tick();
    chk("e_inj_valid", req_valid, 1);
    tick();
    chk("e_held", {req_valid, req_srcid, req_payload}, {1'b1, 6'd3, 90'hf});
    rst_n = 1'b0;
    tick();
    chk("e_rst_drop", req_valid, 0);
    chk("e_rst_idle", idle, 1);
    rst_n = 1'b1;
    req_ready = 1'b1;
    tick();
    tick();
    chk("e_no_resume", req_valid, 0);
    chk("q_req_empty", req_q.size(), 0);
    chk("q_rsp_empty", rsp_q.size(), 0);
    chk("q_done_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
